keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart of the multiplexed 7-seg display driver. The display
//  scans digit enables out; this block scans a 4x4 matrix keypad in: drives
//  columns low one at a time, reads the rows, debounces, and hands one key code
//  per press to downstream logic (toaster time entry) via a valid/ack handshake.
//  Runs on the 2 kHz PLL clock that also steps the display digit counter.
// PARAMETERS
//  SCAN_DWELL       4  cycles each column is driven; rows sampled on last cycle (>=3)
//  DEBOUNCE_CYCLES  8  consecutive stable cycles needed to accept press / release (>=1)
// PORTS
//  clk        in   1  2 kHz system clock (PLL c0)
//  reset      in   1  asynchronous, active-high reset
//  kpr        in   4  keypad rows, active-low (external pull-ups), asynchronous
//  kpc        out  4  keypad column drive, active-low, one-hot-low
//  key_code   out  4  code of last accepted key
//  key_valid  out  1  new key_code available; held until acknowledged
//  key_ack    in   1  consumer accepts key_code (1-cycle pulse or level)
//  key_held   out  1  a debounced key is currently pressed
//  overrun    out  1  sticky: key accepted while key_valid was still high
// BEHAVIOUR
//  Reset values: kpc=4'b1110 (col 0), key_code=0, key_valid=0, key_held=0,
//   overrun=0, FSM=SCAN, dwell/debounce counters=0, synchronizer flops=4'hF.
//  kpr passes through 2-flop synchronizer (rs); all decisions use rs.
//  Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
//   codes: digits = value, A..D = 10..13, * = 14, # = 15.
//  FSM states:
//  - SCAN: dwell counter counts 0..SCAN_DWELL-1 per column; on last cycle rs sampled:
//     exactly one row low -> latch row/col, counter clear, go DEBOUNCE (kpc holds);
//     rs=4'hF or >1 row low (ghost/multi-key) -> advance column, wrap col3->col0.
//  - DEBOUNCE: rs == latched pattern -> count++; mismatch -> SCAN, advance column.
//     count reaches DEBOUNCE_CYCLES -> go HELD; same edge: key_code<=map(row,col),
//     key_valid<=1, key_held<=1.
//  - HELD: kpc holds column. rs==4'hF counts toward release; any low row clears count.
//     DEBOUNCE_CYCLES consecutive all-high -> key_held<=0, SCAN at next column.
//  Latency: physical press stable from cycle of column sample -> key_valid rises
//   DEBOUNCE_CYCLES+1 cycles after that sample (+2 synchronizer cycles from pin).
//  Handshake: key_ack with key_valid=1 -> key_valid<=0 and overrun<=0 next edge.
//   key_ack with key_valid=0 ignored. New key accepted while key_valid=1 and no ack:
//   key_code overwritten, key_valid stays 1, overrun<=1.
//   Accept and ack on same edge: new key wins, key_valid=1, overrun unchanged (0).
//  One key_valid per physical press; auto-repeat not supported; holding a key
//   never re-triggers. Second key pressed while HELD ignored until full release.
//  Reset asserted mid-press or mid-debounce: immediate return to reset values;
//   after release of reset a still-held key is re-detected as a new press.
//  Widths: dwell counter $clog2(SCAN_DWELL), debounce counter
//   $clog2(DEBOUNCE_CYCLES+1); counters saturate, never wrap.
// TESTING
//  1 idle, rows all high 40 cycles -> kpc cycles 1110,1101,1011,0111,1110 every 4 clk;
//    key_valid=0.
//  2 press '5' (row1 low when kpc=1101), hold 30 cycles -> kpc frozen 1101,
//    key_code=5, key_valid=1 exactly 9 cycles after sample; key_held=1 until release.
//  3 '#' bounce: row3 toggles every 3 cycles under col2 -> no key_valid; scanning
//    resumes; then stable hold -> key_code=15.
//  4 ack timing: after '0' accepted, key_ack pulse -> key_valid=0 next cycle;
//    press 'D' without ack after '7' -> key_code=13, overrun=1; ack clears both.
//  5 rows 0 and 2 low under col0 -> ignored, no key_valid, column keeps advancing.
//  6 reset during HELD of 'A' -> all outputs to reset values asynchronously;
//    'A' still held after reset -> new key_valid with key_code=10.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, synchronizes and
// debounces the row inputs, and presents one key code per press on a valid/ack handshake.
module keypad_scanner #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW  = $clog2(SCAN_DWELL);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [DW-1:0]  DWELL_ONE  = DW'(1);
    localparam logic [DW-1:0]  DWELL_ZERO = DW'(0);
    localparam logic [DBW-1:0] DEB_DONE   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DEB_REL    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_ONE    = DBW'(1);
    localparam logic [DBW-1:0] DEB_ZERO   = DBW'(0);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    function automatic logic single_low(input logic [3:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~p[i]};
        end
        return (n == 3'd1);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!p[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b0000: code = 4'd1;
            4'b0001: code = 4'd2;
            4'b0010: code = 4'd3;
            4'b0011: code = 4'd10;
            4'b0100: code = 4'd4;
            4'b0101: code = 4'd5;
            4'b0110: code = 4'd6;
            4'b0111: code = 4'd11;
            4'b1000: code = 4'd7;
            4'b1001: code = 4'd8;
            4'b1010: code = 4'd9;
            4'b1011: code = 4'd12;
            4'b1100: code = 4'd14;
            4'b1101: code = 4'd0;
            4'b1110: code = 4'd15;
            4'b1111: code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_rs1, r_rs2;
    logic [3:0]      r_kpc, w_kpc_nxt;
    logic [DW-1:0]   r_dwell, w_dwell_nxt;
    logic [DBW-1:0]  r_deb, w_deb_nxt;
    logic [3:0]      r_pat, w_pat_nxt;
    logic [3:0]      r_code, w_code_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_held, w_held_nxt;
    logic            r_overrun, w_overrun_nxt;
    logic            w_accept;
    logic [3:0]      w_kpc_rot;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs1 <= 4'hF;
            r_rs2 <= 4'hF;
        end else begin
            r_rs1 <= kpr;
            r_rs2 <= r_rs1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counters, latched pattern and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_kpc_nxt     = r_kpc;
        w_dwell_nxt   = r_dwell;
        w_deb_nxt     = r_deb;
        w_pat_nxt     = r_pat;
        w_code_nxt    = r_code;
        w_valid_nxt   = r_valid;
        w_held_nxt    = r_held;
        w_overrun_nxt = r_overrun;
        w_accept      = 1'b0;
        w_kpc_rot     = {r_kpc[2:0], r_kpc[3]};

        case (r_state)
            S_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = DWELL_ZERO;
                    if (single_low(r_rs2)) begin
                        w_pat_nxt   = r_rs2;
                        w_deb_nxt   = DEB_ZERO;
                        w_state_nxt = S_DEBOUNCE;
                    end else begin
                        w_kpc_nxt = w_kpc_rot;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (r_rs2 != r_pat) begin
                    w_state_nxt = S_SCAN;
                    w_kpc_nxt   = w_kpc_rot;
                    w_dwell_nxt = DWELL_ZERO;
                    w_deb_nxt   = DEB_ZERO;
                end else if (r_deb == DEB_DONE) begin
                    w_state_nxt = S_HELD;
                    w_deb_nxt   = DEB_ZERO;
                    w_accept    = 1'b1;
                end else begin
                    w_deb_nxt = r_deb + DEB_ONE;
                end
            end
            S_HELD: begin
                // Release needs DEBOUNCE_CYCLES consecutive all-high samples
                if (r_rs2 != 4'hF) begin
                    w_deb_nxt = DEB_ZERO;
                end else if (r_deb >= DEB_REL) begin
                    w_state_nxt = S_SCAN;
                    w_kpc_nxt   = w_kpc_rot;
                    w_dwell_nxt = DWELL_ZERO;
                    w_deb_nxt   = DEB_ZERO;
                    w_held_nxt  = 1'b0;
                end else begin
                    w_deb_nxt = r_deb + DEB_ONE;
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
                w_kpc_nxt   = 4'b1110;
                w_dwell_nxt = DWELL_ZERO;
                w_deb_nxt   = DEB_ZERO;
            end
        endcase

        // A newly accepted key takes priority over a same-cycle ack
        if (w_accept) begin
            w_code_nxt  = key_map(low_idx(r_pat), low_idx(r_kpc));
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            if (r_valid && !key_ack) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_overrun_nxt = r_overrun;
            end
        end else if (key_ack && r_valid) begin
            w_valid_nxt   = 1'b0;
            w_overrun_nxt = 1'b0;
        end else begin
            w_valid_nxt = w_valid_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kpc     <= 4'b1110;
            r_dwell   <= DWELL_ZERO;
            r_deb     <= DEB_ZERO;
            r_pat     <= 4'hF;
            r_code    <= 4'd0;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_kpc     <= w_kpc_nxt;
            r_dwell   <= w_dwell_nxt;
            r_deb     <= w_deb_nxt;
            r_pat     <= w_pat_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_held    <= w_held_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign kpc       = r_kpc;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows and a
// scoreboard queue of expected key codes is checked each time a new key is accepted.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  kpr;
    logic [3:0]  kpc;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic [3:0]  sb_exp;
    logic        prev_held = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .kpr       (kpr),
        .kpc       (kpc),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads low when a pressed key sits on the driven column
    always_comb begin
        kpr = 4'hF;
        for (int r = 0; r < 4; r++) begin
            kpr[r] = ~|(pressed[r*4 +: 4] & ~kpc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each new acceptance (key_held rising) pops one expected code
    always @(negedge clk) begin
        if (key_held === 1'b1 && prev_held === 1'b0) begin
            check_eq("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                check_eq("sb_key_code", 32'(key_code), 32'(sb_exp));
                check_eq("sb_key_valid", 32'(key_valid), 32'd1);
            end
        end
        prev_held = key_held;
    end

    task automatic press(input int row, input int col, input logic [3:0] code);
        pressed[row*4 + col] = 1'b1;
        exp_q.push_back(code);
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string tag);
        int k;
        k = 0;
        while (key_held !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(key_held), 32'(lvl));
    endtask

    task automatic ack_pulse(input string tag);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check_eq({tag, "_ack_valid"}, 32'(key_valid), 32'd0);
        check_eq({tag, "_ack_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev_kpc;
        logic [3:0] exp_kpc;
        int         lat;
        int         cnt;
        logic       found;

        reset   = 1'b1;
        key_ack = 1'b0;
        pressed = 16'h0000;
        @(negedge clk);
        check_eq("rst_kpc", 32'(kpc), 32'h E);
        check_eq("rst_code", 32'(key_code), 32'd0);
        check_eq("rst_valid", 32'(key_valid), 32'd0);
        check_eq("rst_held", 32'(key_held), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;

        // 1: idle scan, column advances every 4 clocks
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            exp_kpc = 4'b1111 & ~(4'b0001 << ((n / 4) % 4));
            check_eq("idle_kpc", 32'(kpc), 32'(exp_kpc));
        end
        check_eq("idle_valid", 32'(key_valid), 32'd0);

        // 2: press '5', latency from column strobe and freeze while held
        press(1, 1, 4'd5);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_kpc = kpc;
            @(negedge clk);
            if (kpc == 4'b1101 && prev_kpc != 4'b1101) found = 1'b1;
        end
        check_eq("t2_col1_reached", 32'(found), 32'd1);
        lat = 0;
        while (key_valid !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t2_valid_latency", 32'(lat), 32'd13);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (kpc == 4'b1101 && key_held === 1'b1 && key_code == 4'd5) cnt++;
        end
        check_eq("t2_hold_frozen", 32'(cnt), 32'd30);
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t2_release");
        check_eq("t2_next_col", 32'(kpc), 32'h B);
        ack_pulse("t2");

        // 3: bouncing '#' never accepted, then a clean press is
        for (int i = 0; i < 20; i++) begin
            pressed[14] = ~pressed[14];
            repeat (3) @(negedge clk);
        end
        check_eq("t3_bounce_valid", 32'(key_valid), 32'd0);
        check_eq("t3_bounce_held", 32'(key_held), 32'd0);
        pressed = 16'h0000;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            prev_kpc = kpc;
            @(negedge clk);
            if (kpc != prev_kpc) cnt++;
        end
        check_eq("t3_scan_resumes", 32'(cnt >= 3), 32'd1);
        press(3, 2, 4'd15);
        wait_held(1'b1, 60, "t3_hash_held");
        repeat (10) @(negedge clk);
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t3_release");
        ack_pulse("t3");

        // 4: ack timing, then overrun on unacknowledged '7' followed by 'D'
        press(3, 1, 4'd0);
        wait_held(1'b1, 60, "t4_zero_held");
        check_eq("t4_valid_before_ack", 32'(key_valid), 32'd1);
        ack_pulse("t4_zero");
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t4_zero_release");
        press(2, 0, 4'd7);
        wait_held(1'b1, 60, "t4_seven_held");
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t4_seven_release");
        check_eq("t4_no_overrun_yet", 32'(overrun), 32'd0);
        press(3, 3, 4'd13);
        wait_held(1'b1, 60, "t4_d_held");
        check_eq("t4_d_code", 32'(key_code), 32'd13);
        check_eq("t4_d_valid", 32'(key_valid), 32'd1);
        check_eq("t4_d_overrun", 32'(overrun), 32'd1);
        ack_pulse("t4_d");
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t4_d_release");

        // 5: two rows low under column 0 is ignored and scanning continues
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            prev_kpc = kpc;
            @(negedge clk);
            if (kpc != prev_kpc) cnt++;
        end
        check_eq("t5_col_changes", 32'(cnt), 32'd10);
        check_eq("t5_valid", 32'(key_valid), 32'd0);
        check_eq("t5_held", 32'(key_held), 32'd0);
        pressed = 16'h0000;
        repeat (4) @(negedge clk);

        // 6: asynchronous reset while 'A' is held, then re-detection
        press(0, 3, 4'd10);
        wait_held(1'b1, 60, "t6_a_held");
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_kpc", 32'(kpc), 32'h E);
        check_eq("t6_rst_code", 32'(key_code), 32'd0);
        check_eq("t6_rst_valid", 32'(key_valid), 32'd0);
        check_eq("t6_rst_held", 32'(key_held), 32'd0);
        check_eq("t6_rst_overrun", 32'(overrun), 32'd0);
        exp_q.push_back(4'd10);
        @(negedge clk);
        reset = 1'b0;
        wait_held(1'b1, 80, "t6_a_redetect");
        check_eq("t6_a_code", 32'(key_code), 32'd10);
        pressed = 16'h0000;
        wait_held(1'b0, 40, "t6_release");
        ack_pulse("t6");

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
